// File: rtl/sseg_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Segment patterns are active-low, bit 0 = a through bit 6 = g.
package sseg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    SEL_ONES      = 2'd0,
    SEL_TENS      = 2'd1,
    SEL_HUNDREDS  = 2'd2,
    SEL_THOUSANDS = 2'd3
  } digit_sel_t;

  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/sseg_decoder.sv
// Combinational BCD to active-low seven-segment decoder; 10-15 show a dash.
module sseg_decoder
  import sseg_pkg::*;
(
  input  bcd_t digit,
  output seg_t seg
);

  // Table lookup; anything outside 0-9 falls through to the dash pattern
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sseg4_scan.sv
// Four-digit multiplexed seven-segment scanner. Digits are captured on load,
// then shown one at a time for DIV_COUNT clocks each, ones digit first.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits
// (the ones digit always stays lit).
module sseg4_scan
  import sseg_pkg::*;
#(
  parameter int DIV_COUNT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;

  logic [CW-1:0] cnt;
  logic          tick;
  digit_sel_t    sel;
  bcd_t          hold [4];
  bcd_t          cur;
  seg_t          dec_seg;
  logic          blank;

  assign tick = (cnt == CW'(DIV_COUNT - 1));
  assign cur  = hold[sel];
  assign dp   = 1'b1;

  // Prescaler: counts 0..DIV_COUNT-1 and wraps, tick marks the last count
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Digit select walks ones -> tens -> hundreds -> thousands on each tick
  always_ff @(posedge clk) begin
    if (rst)       sel <= SEL_ONES;
    else if (tick) sel <= digit_sel_t'(sel + 2'd1);
  end

  // Hold registers isolate the display from the upstream converter between loads
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hold[i] <= '0;
    end else if (load) begin
      hold[0] <= ones;
      hold[1] <= tens;
      hold[2] <= hundreds;
      hold[3] <= thousands;
    end
  end

  // Blank the selected digit when it and everything above it is zero
  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (sel)
      SEL_TENS:      blank = (hold[1] == 4'd0) && (hold[2] == 4'd0) && (hold[3] == 4'd0);
      SEL_HUNDREDS:  blank = (hold[2] == 4'd0) && (hold[3] == 4'd0);
      SEL_THOUSANDS: blank = (hold[3] == 4'd0);
      default:       blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  sseg_decoder u_dec (
    .digit (cur),
    .seg   (dec_seg)
  );

  // Registered anode/cathode drive, one cycle behind select and hold
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else if (blank) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= ~(4'b0001 << sel);
      seg <= dec_seg;
    end
  end

endmodule

// File: doc/sseg4_scan.md
SSEG4_SCAN -- requirements
Module: sseg4_scan

Interface
REQ-001 SHALL have parameter DIV_COUNT, default 100000; clk cycles each digit is shown (range 2..2^20).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port load, input, 1 bit: capture strobe for the digit inputs.
REQ-005 SHALL have ports thousands, hundreds, tens, ones, input, 4 bits each: BCD digits from the upstream binary-to-BCD converter.
REQ-006 SHALL have port an, output, 4 bits: active-low digit anodes; bit 0 is the rightmost (ones) digit.
REQ-007 SHALL have port seg, output, 7 bits: active-low cathodes, bit 0 = a through bit 6 = g.
REQ-008 SHALL have port dp, output, 1 bit: active-low decimal point; always 1 (off).

Function
REQ-009 SHALL capture all four digit inputs into hold registers on every clock edge where load=1; without load, the hold registers keep their value.
REQ-010 SHALL run a prescale counter 0..DIV_COUNT-1 that wraps to 0; tick is asserted when the count equals DIV_COUNT-1.
REQ-011 SHALL advance a 2-bit digit select on tick, in the order 0 (ones), 1 (tens), 2 (hundreds), 3 (thousands), then wrap to 0.
REQ-012 SHALL register an and seg, giving 1-cycle latency from the select and hold registers to the outputs.
REQ-013 SHALL drive exactly one an bit low (the selected digit) unless that digit is blanked; a blanked digit drives an=4'b1111 and seg=7'b1111111.
REQ-014 SHALL decode held values 0-9 to standard seven-segment patterns; a value of 10-15 SHALL display a dash (seg=7'b0111111, g only).
REQ-015 When load coincides with tick, the new digits SHALL appear on the outputs on the edge after capture.
REQ-016 A change on the digit inputs without load SHALL NOT affect the outputs.

Reset
REQ-017 On any edge where rst=1, the block SHALL clear the prescale counter, the select and all hold registers to 0, and set an=4'b1111, seg=7'b1111111, dp=1.
REQ-018 rst SHALL take priority over load and tick.
REQ-019 A reset asserted mid-scan SHALL restart the scan at the ones digit.
REQ-020 On the first edge after rst falls, the outputs SHALL show held digit 0 on an=4'b1110.

Configuration
REQ-021 With LEADING_ZERO_BLANK_EN defined, the block SHALL blank a digit if it and every more-significant held digit are 0.
REQ-022 The ones digit SHALL never be blanked.
REQ-023 Without LEADING_ZERO_BLANK_EN, the block SHALL never blank any digit.

Structure
REQ-024 Package sseg_pkg SHALL hold the BCD digit typedef (4 bits), the segment-pattern typedef (7 bits), constants SEG_0..SEG_9, SEG_DASH and SEG_OFF, and the anode constant AN_OFF.
REQ-025 Combinational sub-module sseg_decoder SHALL map a BCD digit to a segment pattern.
REQ-026 sseg4_scan SHALL instantiate sseg_decoder once, on the selected digit.

Verification (DIV_COUNT=4)
REQ-027 Reset scenario: rst for 3 cycles, then release -> an=1111 and seg=1111111 during reset; next edge an=1110, seg=SEG_0.
REQ-028 Scan scenario: load digits 1,2,3,4 (thousands..ones) -> an steps 1110/1101/1011/0111 every 4 cycles, seg SEG_4/SEG_3/SEG_2/SEG_1, then wraps to 1110.
REQ-029 Blanking scenario, macro on: load 0,0,0,7 -> only the ones slot lights (SEG_7); the other three slots give an=1111. Macro off: the other slots show SEG_0.
REQ-030 Invalid-BCD and input-isolation scenario: load ones=4'hC -> ones slot shows SEG_DASH; changing inputs with load=0 leaves seg unchanged.
REQ-031 Coincidence and mid-scan reset scenario: load on a tick edge -> new value visible on the next edge; rst in the hundreds slot -> next output an=1110 with all digits 0 (ones slot shows SEG_0).
REQ-032 Converter-chain scenario: sweep binary 0..2047 through the binary-to-BCD converter with load every 16 cycles -> each displayed digit equals the converter output; with the macro on, 5 shows only the ones slot lit.
